// File: rtl/dp_result_buffer.sv
// dp_result_buffer: FIFO of ALU results packed {carry, zero, alu}; optional flag counters under DP_RESULT_STATS_EN.
// Latency: a write shows on out_valid the cycle after its edge; the head entry is driven combinationally from storage.
// Backpressure: out_ready=0 holds the head stable; a write when full without a read is dropped and sets sticky overflow.
module dp_result_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [3:0]               in_alu,
  input  logic                     in_carry,
  input  logic                     in_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
`ifdef DP_RESULT_STATS_EN
  ,
  input  logic                     clr_stats,
  output logic [7:0]               zero_cnt,
  output logic [7:0]               carry_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_rd;
  logic          do_wr;
  logic          drop;

  // Handshake decode: a read frees a slot, so a full buffer still takes a write on a read cycle
  always_comb begin
    full      = (level == FULL_LEVEL);
    out_valid = (level != '0);
    do_rd     = out_valid && out_ready;
    do_wr     = in_valid && (!full || do_rd);
    drop      = in_valid && full && !do_rd;
    out_data  = mem[rd_ptr];
  end

  // Storage is deliberately not reset; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= {in_carry, in_zero, in_alu};
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks the occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      level <= level + 1'b1;
      else if (do_rd && !do_wr) level <= level - 1'b1;
    end
  end

  // Sticky overflow: a drop in the same cycle wins over the clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef DP_RESULT_STATS_EN
  // Saturating flag counters over accepted writes; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_cnt  <= 8'd0;
      carry_cnt <= 8'd0;
    end else if (clr_stats) begin
      zero_cnt  <= 8'd0;
      carry_cnt <= 8'd0;
    end else if (do_wr) begin
      if (in_zero && zero_cnt != 8'hFF)   zero_cnt  <= zero_cnt + 8'd1;
      if (in_carry && carry_cnt != 8'hFF) carry_cnt <= carry_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dp_result_buffer.sv
// tb_dp_result_buffer: scoreboard bench for dp_result_buffer at DEPTH=8.
// Latency: expected entries are queued on accepted writes and compared against the head every cycle.
// Backpressure: out_ready is driven per scenario; drops when full are modelled as never entering the queue.
module tb_dp_result_buffer;

  localparam int DEPTH = 8;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_alu;
  logic       in_carry;
  logic       in_zero;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic [3:0] level;
  logic       overflow;
  logic       clr_ovf;
`ifdef DP_RESULT_STATS_EN
  logic       clr_stats;
  logic [7:0] zero_cnt;
  logic [7:0] carry_cnt;
`endif

  int total;
  int bad;

  // scoreboard state
  logic [5:0] model [$];
  logic       exp_ovf;
  logic       m_rd;
  logic       m_acc;
  logic       m_drop;
  int         exp_zc;
  int         exp_cc;

  dp_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_alu    (in_alu),
    .in_carry  (in_carry),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
`ifdef DP_RESULT_STATS_EN
    ,
    .clr_stats (clr_stats),
    .zero_cnt  (zero_cnt),
    .carry_cnt (carry_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] alu, input logic c, input logic z);
    in_valid = 1'b1;
    in_alu   = alu;
    in_carry = c;
    in_zero  = z;
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard: check DUT state against the model, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    if (!reset) begin
      model.delete();
      exp_ovf = 1'b0;
      exp_zc  = 0;
      exp_cc  = 0;
    end else begin
      check("sb_level", 32'(level), 32'(model.size()));
      check("sb_valid", 32'(out_valid), 32'(model.size() != 0));
      check("sb_ovf", 32'(overflow), 32'(exp_ovf));
      if (model.size() != 0) check("sb_data", 32'(out_data), 32'(model[0]));
`ifdef DP_RESULT_STATS_EN
      check("sb_zcnt", 32'(zero_cnt), 32'(exp_zc));
      check("sb_ccnt", 32'(carry_cnt), 32'(exp_cc));
`endif
      m_rd   = out_ready && (model.size() != 0);
      m_acc  = in_valid && ((model.size() < DEPTH) || m_rd);
      m_drop = in_valid && !m_acc;
      if (m_rd) void'(model.pop_front());
      if (m_acc) model.push_back({in_carry, in_zero, in_alu});
      if (m_drop) exp_ovf = 1'b1;
      else if (clr_ovf) exp_ovf = 1'b0;
`ifdef DP_RESULT_STATS_EN
      if (clr_stats) begin
        exp_zc = 0;
        exp_cc = 0;
      end else if (m_acc) begin
        if (in_zero && exp_zc < 255) exp_zc++;
        if (in_carry && exp_cc < 255) exp_cc++;
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int maxl;
    logic [5:0] last;

    total = 0;
    bad = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    in_alu = 4'h0;
    in_carry = 1'b0;
    in_zero = 1'b0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
`ifdef DP_RESULT_STATS_EN
    clr_stats = 1'b0;
`endif
    tick();
    tick();
    check("rst_level", 32'(level), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset = 1'b1;
    tick();

    // three results held back, then drained in order
    wr(4'h5, 1'b0, 1'b0);
    wr(4'h0, 1'b0, 1'b1);
    wr(4'hF, 1'b0, 1'b0);
    check("hold_level", 32'(level), 3);
    check("hold_head", 32'(out_data), 32'h05);
    tick();
    check("hold_stable", 32'(out_data), 32'h05);
    out_ready = 1'b1;
    tick();
    check("drain_2nd", 32'(out_data), 32'h10);
    tick();
    check("drain_3rd", 32'(out_data), 32'h0F);
    tick();
    check("drain_level", 32'(level), 0);

    // fill to full, drop the ninth while clearing overflow in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr(4'(i), i[0], (i == 0));
    end
    check("full_level", 32'(level), 8);
    check("full_ovf0", 32'(overflow), 0);
    clr_ovf = 1'b1;
    wr(4'hE, 1'b1, 1'b1);
    check("drop_ovf", 32'(overflow), 1);
    check("drop_level", 32'(level), 8);
    tick();
    check("clr_ovf", 32'(overflow), 0);
    clr_ovf = 1'b0;

    // write and read together at full: no overflow, new entry goes last
    out_ready = 1'b1;
    wr(4'hC, 1'b1, 1'b0);
    check("full_rw_level", 32'(level), 8);
    check("full_rw_ovf", 32'(overflow), 0);
    n = 0;
    last = 6'h00;
    for (int k = 0; k < 20; k++) begin
      if (!out_valid) break;
      last = out_data;
      n++;
      tick();
    end
    check("full_drain_cnt", 32'(n), 8);
    check("full_drain_last", 32'(last), 32'h2C);

    // continuous write with continuous read wraps the pointers
    check("stream_idle", 32'(out_valid), 0);
    maxl = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_alu   = 4'(i);
      in_carry = i[1];
      in_zero  = i[2];
      tick();
      if (i == 0) check("first_latency", 32'(out_valid), 1);
      if (int'(level) > maxl) maxl = int'(level);
    end
    in_valid = 1'b0;
    tick();
    check("stream_max_level", 32'(maxl), 1);
    check("stream_end_level", 32'(level), 0);

    // reset mid-operation discards everything
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(4'(i + 3), 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 5);
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_level", 32'(level), 0);
    tick();
    reset = 1'b1;
    wr(4'hA, 1'b1, 1'b0);
    check("post_rst_head", 32'(out_data), 32'h2A);
    check("post_rst_level", 32'(level), 1);
    check("post_rst_wptr", 32'(dut.wr_ptr), 1);
    out_ready = 1'b1;
    tick();
    check("post_rst_drain", 32'(level), 0);

`ifdef DP_RESULT_STATS_EN
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    in_valid = 1'b1;
    in_alu   = 4'h0;
    in_carry = 1'b0;
    in_zero  = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    tick();
    check("zero_sat", 32'(zero_cnt), 255);
    check("carry_idle", 32'(carry_cnt), 0);
    clr_stats = 1'b1;
    wr(4'h1, 1'b1, 1'b1);
    clr_stats = 1'b0;
    check("stats_clr_zero", 32'(zero_cnt), 0);
    check("stats_clr_carry", 32'(carry_cnt), 0);
    tick();
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_result_buffer.md
DP_RESULT_BUFFER -- requirements
Module: dp_result_buffer

Interface
REQ-001 Parameter DEPTH, default 8: number of result entries; SHALL be a power of two, 2..64.
REQ-002 Signal `clk`, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-003 Signal `reset`, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Signal `in_valid`, input, 1 bit: ALU result valid strobe (ALU valid_out).
REQ-005 Signal `in_alu`, input, 4 bits: ALU result.
REQ-006 Signal `in_carry`, input, 1 bit: ALU carry.
REQ-007 Signal `in_zero`, input, 1 bit: ALU zero flag.
REQ-008 Signal `out_valid`, output, 1 bit: head entry available.
REQ-009 Signal `out_ready`, input, 1 bit: consumer accepts the head entry.
REQ-010 Signal `out_data`, output, 6 bits: head entry, packed as {carry, zero, alu[3:0]}.
REQ-011 Signal `level`, output, clog2(DEPTH)+1 bits: current entry count.
REQ-012 Signal `overflow`, output, 1 bit: sticky flag, set when a result was dropped.
REQ-013 Signal `clr_ovf`, input, 1 bit: synchronous clear of `overflow`.

Function
REQ-014 Write: an entry SHALL be accepted when in_valid=1 and (level<DEPTH or a read occurs in the same cycle).
REQ-015 Read: a pop SHALL occur when out_valid=1 and out_ready=1.
REQ-016 out_valid SHALL equal (level!=0); out_data SHALL be the oldest entry, shown ahead combinationally from storage.
REQ-017 Latency: a write into an empty buffer SHALL assert out_valid on the cycle after the write edge.
REQ-018 A write and a read while empty SHALL NOT occur; out_valid=0 blocks the read, the write is accepted, and level becomes 1.
REQ-019 Simultaneous write and read when 0<level<DEPTH SHALL leave level unchanged and preserve FIFO order.
REQ-020 Simultaneous write and read when level=DEPTH SHALL accept the write and leave level=DEPTH with no overflow.
REQ-021 A write when full with no read SHALL drop the data, leave storage and level unchanged, and set overflow=1 on the next edge.
REQ-022 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-023 level SHALL change by +1 on write only, -1 on read only, and 0 on both or neither.
REQ-024 clr_ovf=1 SHALL clear overflow, except that an overflow event in the same cycle takes priority and overflow stays 1.
REQ-025 When out_valid=1 and out_ready=0, out_data SHALL remain stable.

Reset
REQ-026 reset=0 SHALL asynchronously force the pointers to 0, level=0, out_valid=0 and overflow=0.
REQ-027 Storage contents are not reset; out_data SHALL be don't-care while out_valid=0.
REQ-028 A reset asserted mid-operation SHALL discard all entries; after release the first in_valid SHALL be stored at entry 0.

Configuration
REQ-029 With macro DP_RESULT_STATS_EN defined, the block SHALL add the following ports:
- `clr_stats`: input, 1 bit.
- `zero_cnt`: output, 8 bits.
- `carry_cnt`: output, 8 bits.
REQ-030 Under DP_RESULT_STATS_EN, zero_cnt and carry_cnt SHALL increment for each accepted write with in_zero=1 and in_carry=1 respectively.
REQ-031 Under DP_RESULT_STATS_EN, both counters SHALL saturate at 255.
REQ-032 Under DP_RESULT_STATS_EN, both counters SHALL reset to 0; clr_stats=1 SHALL clear them, taking priority over a same-cycle increment.
REQ-033 Without DP_RESULT_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Write 3 results (alu=5,0,0xF with flags) with out_ready=0, then raise out_ready -> out_data=0x05, 0x10|0x00, 0x0F in order; level goes 3 -> 0.
REQ-035 With DEPTH=8, write 9 results and no reads -> level=8, overflow=1, and the 9th result is absent on drain.
REQ-036 At level=8, pulse in_valid with out_ready=1 in the same cycle -> level stays 8, overflow stays 0, and the new entry emerges last.
REQ-037 Assert clr_ovf in the same cycle as a full-buffer drop -> overflow=1; assert clr_ovf alone the next cycle -> overflow=0.
REQ-038 Write 20 entries with continuous reads -> pointers wrap, data stays in order, level never exceeds 1, and out_valid asserts one cycle after the first write.
REQ-039 Assert reset while level=5 -> out_valid=0 and level=0 immediately; with DP_RESULT_STATS_EN, 300 zero-flag writes -> zero_cnt=255.
